// File: rtl/gate_tt_pkg.sv
// Purpose: shared types and sizing for the 2-input gate truth-table sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gate_tt_pkg;

    localparam int NUM_VECTORS = 4;
    localparam int IDX_W       = 2;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/settle_timer.sv
// Purpose: settle down-counter; expired marks the last wait cycle of a vector.
// Latency: load takes effect next cycle; a load of N gives N cycles before expiry completes.
// Backpressure: none; load always wins over counting.
module settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt;

    // Load on request, otherwise count down to zero and park there.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    // A count of 1 is the final settle cycle; <= keeps the FSM from ever stalling at 0.
    assign expired = (cnt <= W'(1));

endmodule

// File: rtl/gate_tt_sequencer.sv
// Purpose: drive all four {a,b} vectors into a 2-input gate and grade its output against a truth table.
// Latency: settle_cycles+2 cycles per vector; done lands 4*(settle_cycles+2)+1 cycles after start accept.
// Backpressure: start is only accepted in IDLE; it is dropped while busy (including the DONE cycle).
module gate_tt_sequencer
    import gate_tt_pkg::*;
#(
    parameter int SETTLE_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [3:0]          expected_tt,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic                gate_out,
    output logic                a_o,
    output logic                b_o,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [3:0]          fail_mask,
    output logic [2:0]          err_count
);

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          exp_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [IDX_W-1:0]    idx;
    logic                tmr_load;
    logic                tmr_expired;
    logic                mismatch;
    logic                last_vec;
    logic [2:0]          err_total;

    settle_timer #(
        .W(SETTLE_W)
    ) u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .value   (settle_q),
        .expired (tmr_expired)
    );

    assign mismatch  = (gate_out != exp_q[idx]);
    assign last_vec  = (idx == IDX_W'(NUM_VECTORS - 1));
    assign err_total = err_count + {2'b00, mismatch};

    // State register; reset aborts any sweep in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus state-derived status outputs (no path from gate_out).
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                tmr_load  = 1'b1;
                state_nxt = (settle_q == '0) ? SAMPLE : SETTLE;
            end
            SETTLE: begin
                if (tmr_expired) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                state_nxt = last_vec ? DONE : DRIVE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sweep datapath: capture config at accept, drive vectors, accumulate mismatches.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q     <= '0;
            settle_q  <= '0;
            idx       <= '0;
            a_o       <= 1'b0;
            b_o       <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q     <= expected_tt;
                        settle_q  <= settle_cycles;
                        idx       <= '0;
                        pass      <= 1'b0;
                        fail_mask <= '0;
                        err_count <= '0;
                    end
                end
                DRIVE: begin
                    a_o <= idx[1];
                    b_o <= idx[0];
                end
                SAMPLE: begin
                    if (mismatch) begin
                        fail_mask[idx] <= 1'b1;
                        err_count      <= err_total;
                    end
                    // Grade on the final vector so pass is valid together with done.
                    if (last_vec) begin
                        pass <= (err_total == 3'd0);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
module tb_gate_tt_sequencer;

    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    expected_tt;
    logic [SW-1:0] settle_cycles;
    logic          gate_out;
    logic          a_o;
    logic          b_o;
    logic          busy;
    logic          done;
    logic          pass;
    logic [3:0]    fail_mask;
    logic [2:0]    err_count;
    logic [1:0]    mode;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Gate under test: 0 = OR, 1 = stuck at 0, 2 = AND
    function automatic logic gate_fn(input logic [1:0] m, input logic a, input logic b);
        case (m)
            2'd0:    return a | b;
            2'd1:    return 1'b0;
            default: return a & b;
        endcase
    endfunction

    assign gate_out = gate_fn(mode, a_o, b_o);

    gate_tt_sequencer #(.SETTLE_W(SW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .expected_tt   (expected_tt),
        .settle_cycles (settle_cycles),
        .gate_out      (gate_out),
        .a_o           (a_o),
        .b_o           (b_o),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail_mask     (fail_mask),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Timeline of one sweep, k = cycles since the accept edge (k=1 is the first cycle
    // after accept): vector v's value appears on a/b at k = 2 + v*(N+2); the
    // sweep ends with done at k = 4*(N+2)+1, after which the block idles.
    bit         m_valid  = 1'b0;
    bit         m_active = 1'b0;
    int         m_k;
    int         m_n;
    int         m_v;
    logic [3:0] m_exp;
    logic [1:0] m_ab;
    logic [3:0] m_mask;
    logic [2:0] m_err;
    logic       m_pass;

    function automatic int done_k(input int n);
        return 4 * (n + 2) + 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_ab     = 2'b00;
            m_mask   = 4'b0000;
            m_err    = 3'd0;
            m_pass   = 1'b0;
        end else if (m_valid) begin
            if (m_active) begin
                if (m_k == done_k(m_n)) m_active = 1'b0;
                else m_k++;
            end else if (start) begin
                m_active = 1'b1;
                m_k      = 1;
                m_n      = int'(settle_cycles);
                m_exp    = expected_tt;
                m_mask   = 4'b0000;
                m_err    = 3'd0;
                m_pass   = 1'b0;
            end
            if (m_active && m_k >= 2) begin
                m_v = (m_k - 2) / (m_n + 2);
                if (m_v > 3) m_v = 3;
                m_ab = m_v[1:0];
            end
            if (m_active && m_k == done_k(m_n)) begin
                m_mask = 4'b0000;
                m_err  = 3'd0;
                for (int i = 0; i < 4; i++) begin
                    logic [1:0] iv;
                    iv = i[1:0];
                    if (gate_fn(mode, iv[1], iv[0]) != m_exp[i]) begin
                        m_mask[i] = 1'b1;
                        m_err     = m_err + 3'd1;
                    end
                end
                m_pass = (m_err == 3'd0);
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", busy, m_active);
            chk("done", done, m_active && m_k == done_k(m_n));
            chk("a_o", a_o, m_ab[1]);
            chk("b_o", b_o, m_ab[0]);
            if (!m_active || m_k == 1 || m_k == done_k(m_n)) begin
                chk("fail_mask", fail_mask, m_mask);
                chk("err_count", err_count, m_err);
                chk("pass", pass, m_pass);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [1:0] ab_seq[$];

    task automatic pulse_start(output int c);
        @(posedge clk);
        #2 start = 1'b1;
        c = cyc;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = -1;
        ab_seq = {};
        ab_seq.push_back({a_o, b_o});
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ({a_o, b_o} !== ab_seq[$]) ab_seq.push_back({a_o, b_o});
            if (done === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, d, ndone;
        rst           = 1'b1;
        start         = 1'b0;
        expected_tt   = 4'b0000;
        settle_cycles = '0;
        mode          = 2'd0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mask", fail_mask, 0);
        chk("rst_err", err_count, 0);
        chk("rst_ab", {a_o, b_o}, 0);

        // OR gate, N=2: clean sweep, done 17 cycles after start
        mode = 2'd0; expected_tt = 4'b1110; settle_cycles = 4'd2;
        pulse_start(c0);
        wait_done(c1);
        chk("or_latency", c1 - c0, 17);
        chk("or_pass", pass, 1);
        chk("or_mask", fail_mask, 0);
        chk("or_err", err_count, 0);
        chk("or_seq_len", ab_seq.size(), 4);
        for (int i = 0; i < 4 && i < ab_seq.size(); i++) chk("or_seq", ab_seq[i], i);

        // AND gate against OR table, N=1: vectors 1 and 2 mismatch
        mode = 2'd2; expected_tt = 4'b1110; settle_cycles = 4'd1;
        pulse_start(c0);
        wait_done(c1);
        chk("and_latency", c1 - c0, 13);
        chk("and_mask", fail_mask, 4'b0110);
        chk("and_err", err_count, 2);
        chk("and_pass", pass, 0);

        // Stuck-at-0 gate, N=2: three mismatches
        mode = 2'd1; expected_tt = 4'b1110; settle_cycles = 4'd2;
        pulse_start(c0);
        wait_done(d);
        chk("stuck_mask", fail_mask, 4'b1110);
        chk("stuck_err", err_count, 3);
        chk("stuck_pass", pass, 0);

        // Back-to-back: start held through DONE (ignored) and the following IDLE (accepted)
        mode  = 2'd0;
        start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 start = 1'b0;
        @(negedge clk);
        chk("b2b_mask_clr", fail_mask, 0);
        chk("b2b_err_clr", err_count, 0);
        wait_done(c1);
        chk("b2b_latency", c1 - d, 18);
        chk("b2b_pass", pass, 1);
        chk("b2b_mask", fail_mask, 0);

        // N=0, AND table, with mid-sweep start and config changes that must be ignored
        mode = 2'd2; expected_tt = 4'b1000; settle_cycles = 4'd0;
        pulse_start(c0);
        repeat (2) @(posedge clk);
        #2 start = 1'b1; expected_tt = 4'b0000; settle_cycles = 4'd5;
        repeat (2) @(posedge clk);
        #2 start = 1'b0;
        wait_done(c1);
        chk("n0_latency", c1 - c0, 9);
        chk("n0_pass", pass, 1);
        chk("n0_mask", fail_mask, 0);

        // Reset during SETTLE of vector 2 (N=3: that vector settles at k=12..14)
        mode = 2'd0; expected_tt = 4'b1110; settle_cycles = 4'd3;
        pulse_start(c0);
        repeat (12) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_ab", {a_o, b_o}, 2'b10);
        chk("pre_rst_busy", busy, 1);
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ab", {a_o, b_o}, 0);
        chk("abort_pass", pass, 0);
        chk("abort_mask", fail_mask, 0);
        chk("abort_err", err_count, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        pulse_start(c0);
        wait_done(c1);
        chk("fresh_latency", c1 - c0, 21);
        chk("fresh_pass", pass, 1);
        chk("fresh_mask", fail_mask, 0);
        chk("fresh_err", err_count, 0);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
